// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory arbiter.
// The latched command is a packed struct so one register captures a whole request.
package mem_arb_pkg;
   localparam int AW = 32;
   localparam int DW = 32;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
   typedef enum logic {REQ_IF = 1'b0, REQ_D = 1'b1} req_id_t;
   typedef struct packed {
      logic [AW-1:0]   addr;
      logic            we;
      logic [DW-1:0]   wdata;
      logic [DW/8-1:0] be;
   } cmd_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the port not granted last wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic    i_req_if,
   input  logic    i_req_d,
   input  req_id_t i_last,
   output req_id_t o_gnt,
   output logic    o_valid
);
   assign o_valid = i_req_if | i_req_d;
   assign o_gnt   = (i_req_if & i_req_d) ? ((i_last == REQ_IF) ? REQ_D : REQ_IF)
                                         : (i_req_d ? REQ_D : REQ_IF);
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises fetch and load/store accesses onto one
// single-port synchronous memory through an IDLE/ISSUE/RESP sequence.
module unified_mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_ack,
   output logic [DW-1:0]   if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata,
   output logic            stall,
   output logic            gnt_id
);
   arb_state_t    r_state, w_next;
   cmd_t          r_cmd, w_cmd;
   req_id_t       r_gnt, r_last, w_pick;
   logic          w_pick_valid, w_req_if, w_req_d, w_issue, w_resp, w_load;
   logic [DW-1:0] r_if_rdata, r_d_rdata;

   assign w_issue  = r_state == ISSUE;
   assign w_resp   = r_state == RESP;
   // mask the port being acked so the other one can take the very next slot
   assign w_req_if = if_req & ~(w_resp & (r_gnt == REQ_IF));
   assign w_req_d  = d_req & ~(w_resp & (r_gnt == REQ_D));

   rr_pick2 u_pick (
      .i_req_if (w_req_if),
      .i_req_d  (w_req_d),
      .i_last   (r_last),
      .o_gnt    (w_pick),
      .o_valid  (w_pick_valid)
   );

   assign w_load = ~w_issue & w_pick_valid;
   assign w_cmd  = (w_pick == REQ_D) ? cmd_t'{addr: d_addr, we: d_we, wdata: d_wdata, be: d_be}
                                     : cmd_t'{addr: if_addr, we: 1'b0, wdata: '0, be: '1};

   always_comb begin
      w_next = w_issue ? RESP : (w_pick_valid ? ISSUE : IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cmd      <= '0;
         r_gnt      <= REQ_IF;
         r_last     <= REQ_IF;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_cmd  <= w_cmd;
            r_gnt  <= w_pick;
            r_last <= w_pick;
         end
         if (if_ack) r_if_rdata <= mem_rdata;
         if (d_ack & ~r_cmd.we) r_d_rdata <= mem_rdata;
      end
   end

   assign if_ack    = w_resp & (r_gnt == REQ_IF);
   assign d_ack     = w_resp & (r_gnt == REQ_D);
   assign if_rdata  = if_ack ? mem_rdata : r_if_rdata;
   assign d_rdata   = (d_ack & ~r_cmd.we) ? mem_rdata : r_d_rdata;
   // memory side is driven only from the latched command, zero outside ISSUE
   assign mem_en    = w_issue;
   assign mem_we    = w_issue & r_cmd.we;
   assign mem_addr  = w_issue ? (r_cmd.addr & ~AW'(3)) : '0;
   assign mem_wdata = w_issue ? r_cmd.wdata : '0;
   assign mem_be    = w_issue ? r_cmd.be : '0;
   assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);
   assign gnt_id    = r_gnt;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed stimulus with a queue scoreboard; a negedge
// monitor pops expected acks/addresses and compares, a behavioural memory answers.
module tb_unified_mem_arbiter;
   logic        clk = 0, reset = 0;
   logic        if_req = 0, d_req = 0, d_we = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [3:0]  d_be = 0;
   logic        if_ack, d_ack, mem_en, mem_we, stall, gnt_id;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 0;
   logic [3:0]  mem_be;

   unified_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .stall(stall), .gnt_id(gnt_id)
   );

   always #5 clk = ~clk;
   int cyc = 0, errors = 0, checks = 0, ack_cnt = 0, n_alt = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [int];
   always @(posedge clk) begin : memory
      logic [31:0] w;
      if (mem_en) begin
         w = mem.exists(int'(mem_addr >> 2)) ? mem[int'(mem_addr >> 2)] : 32'h0;
         mem_rdata <= w;
         if (mem_we) begin
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[int'(mem_addr >> 2)] = w;
         end
      end
   end

   typedef struct {bit chk_data; logic [31:0] data; int at;} exp_t;
   typedef struct {logic [31:0] addr; int at;} mexp_t;
   exp_t  if_q[$], d_q[$];
   mexp_t m_q[$];
   bit    alt_mode = 0;
   logic  last_id = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic fail(input string n);
      checks++;
      errors++;
      $display("FAIL %s: got no response expected one", n);
   endtask

   always @(negedge clk) begin : monitor
      exp_t  e;
      mexp_t m;
      if (reset) begin
         if (if_ack || d_ack) begin
            ack_cnt++;
            chk("no_dual_ack", {31'b0, if_ack & d_ack}, 0);
         end
         if (if_ack) begin
            if (if_q.size() == 0) fail("if_expected_entry");
            else begin
               e = if_q.pop_front();
               if (e.chk_data) chk("if_rdata", if_rdata, e.data);
               if (e.at >= 0) chk("if_ack_cycle", cyc, e.at);
            end
         end
         if (d_ack) begin
            if (d_q.size() == 0) fail("d_expected_entry");
            else begin
               e = d_q.pop_front();
               if (e.chk_data) chk("d_rdata", d_rdata, e.data);
               if (e.at >= 0) chk("d_ack_cycle", cyc, e.at);
            end
         end
         if (mem_en && m_q.size() > 0) begin
            m = m_q.pop_front();
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_en_cycle", cyc, m.at);
         end
         if (alt_mode && (if_ack || d_ack)) begin
            if (n_alt > 0) chk("alternation", {31'b0, d_ack}, {31'b0, ~last_id});
            last_id = d_ack;
            n_alt++;
         end
      end
   end

   task automatic wait_ack(input bit d, input string n);
      int k;
      for (k = 0; k < 30; k++) begin
         @(negedge clk);
         if (d ? d_ack : if_ack) break;
      end
      if (k == 30) fail(n);
      @(posedge clk); #1;
   endtask

   task automatic if_op(input logic [31:0] a, input logic [31:0] ed, input int lat);
      if_req = 1; if_addr = a;
      if_q.push_back('{1'b1, ed, lat < 0 ? -1 : cyc + lat});
      wait_ack(0, "if_ack_timeout");
      if_req = 0;
   endtask

   task automatic d_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit cd, input logic [31:0] ed, input int lat);
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
      d_q.push_back('{cd, ed, lat < 0 ? -1 : cyc + lat});
      wait_ack(1, "d_ack_timeout");
      d_req = 0;
   endtask

   initial begin
      int c0;
      mem[32'h104 >> 2] = 32'h0050_0093;
      mem[32'h200 >> 2] = 32'h1122_3344;
      for (int i = 0; i < 10; i++) begin
         mem[(32'h300 >> 2) + i] = 32'hA000_0000 + i;
         mem[(32'h400 >> 2) + i] = 32'hB000_0000 + i;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1;
      @(negedge clk);
      chk("reset_ctrl", {22'b0, if_ack, d_ack, mem_en, mem_we, stall, gnt_id, mem_be}, 0);
      chk("reset_if_rdata", if_rdata, 0);
      chk("reset_d_rdata", d_rdata, 0);
      chk("reset_mem_addr", mem_addr, 0);
      chk("reset_mem_wdata", mem_wdata, 0);

      // single fetch with cycle-by-cycle stall and memory strobe
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h104;
      if_q.push_back('{1'b1, 32'h0050_0093, cyc + 2});
      m_q.push_back('{32'h104, cyc + 1});
      @(negedge clk);
      chk("stall_T", {31'b0, stall}, 1);
      @(negedge clk);
      chk("stall_T1", {31'b0, stall}, 1);
      chk("mem_be_fetch", {28'b0, mem_be}, 4'hf);
      chk("mem_we_fetch", {31'b0, mem_we}, 0);
      wait_ack(0, "fetch_ack_timeout");
      if_req = 0;

      // partial store then load of the merged word
      d_op(1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 0, 0, 2);
      d_op(0, 32'h200, 0, 4'hf, 1, 32'h1122_BEEF, 2);
      chk("if_rdata_hold", if_rdata, 32'h0050_0093);

      // unaligned fetch lands on the aligned word
      m_q.push_back('{32'h104, cyc + 1});
      if_op(32'h107, 32'h0050_0093, 2);

      // reset asserted while ISSUE is on the memory bus
      if_req = 1; if_addr = 32'h104;
      @(posedge clk); #2;
      chk("issue_before_reset", {31'b0, mem_en}, 1);
      reset = 0; #1;
      chk("async_reset_mem_en", {31'b0, mem_en}, 0);
      if_req = 0;
      @(posedge clk); #1 reset = 1;
      c0 = ack_cnt;
      repeat (4) @(negedge clk);
      chk("no_ack_after_reset", ack_cnt, c0);
      @(posedge clk); #1;

      // first tie after reset: data then fetch
      if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h200;
      d_q.push_back('{1'b1, 32'h1122_BEEF, cyc + 2});
      if_q.push_back('{1'b1, 32'h0050_0093, cyc + 4});
      fork
         begin wait_ack(1, "tie1_d_timeout"); d_req = 0; end
         begin wait_ack(0, "tie1_if_timeout"); if_req = 0; end
      join

      // after a lone data grant, a tie goes to fetch
      d_op(0, 32'h400, 0, 4'hf, 1, 32'hB000_0000, 2);
      if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h404;
      if_q.push_back('{1'b1, 32'hA000_0000, cyc + 2});
      d_q.push_back('{1'b1, 32'hB000_0001, cyc + 4});
      fork
         begin wait_ack(1, "tie2_d_timeout"); d_req = 0; end
         begin wait_ack(0, "tie2_if_timeout"); if_req = 0; end
      join

      // sustained contention: 20 accesses, strict alternation
      c0 = ack_cnt;
      alt_mode = 1;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               if_req = 1; if_addr = 32'h300 + 4 * i;
               if_q.push_back('{1'b1, 32'hA000_0000 + i, -1});
               wait_ack(0, "cont_if_timeout");
            end
            if_req = 0;
         end
         begin
            for (int j = 0; j < 10; j++) begin
               d_req = 1; d_we = 0; d_addr = 32'h400 + 4 * j;
               d_q.push_back('{1'b1, 32'hB000_0000 + j, -1});
               wait_ack(1, "cont_d_timeout");
            end
            d_req = 0;
         end
      join
      alt_mode = 0;
      chk("contention_acks", ack_cnt - c0, 20);
      repeat (3) @(negedge clk);
      chk("if_queue_drained", if_q.size(), 0);
      chk("d_queue_drained", d_q.size(), 0);
      chk("stall_idle", {31'b0, stall}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
